// File: rtl/mem_fill_ctrl_if.sv
// Bus bundle between the cache miss logic, the fill controller and the word memory.
// The controller uses the master view; the cache and memory side use the slave view.
interface mem_fill_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WORDS      = 8
);
  localparam int unsigned OFS_W = $clog2(WORDS);
  localparam int unsigned BLK_W = ADDR_WIDTH - OFS_W - 1;

  logic                  miss_req;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  wt_req;
  logic [ADDR_WIDTH-1:0] wt_addr;
  logic [15:0]           wt_data;
  logic                  wt_ack;
  logic                  fill_busy;
  logic                  fill_we;
  logic [OFS_W-1:0]      fill_word;
  logic [15:0]           fill_data;
  logic [BLK_W-1:0]      fill_blk;
  logic                  tag_we;
  logic                  fill_done;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;
  logic                  mem_rvalid;

  modport master (
    input  miss_req, miss_addr, wt_req, wt_addr, wt_data, mem_rdata, mem_rvalid,
    output wt_ack, fill_busy, fill_we, fill_word, fill_data, fill_blk, tag_we,
           fill_done, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output miss_req, miss_addr, wt_req, wt_addr, wt_data, mem_rdata, mem_rvalid,
    input  wt_ack, fill_busy, fill_we, fill_word, fill_data, fill_blk, tag_we,
           fill_done, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_fill_ctrl.sv
// Cache block fill controller: streams a WORDS-word pipelined read per miss and
// forwards single-cycle write-through stores while idle.
module mem_fill_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned WORDS      = 8
) (
  input  logic           clk,
  input  logic           rst,
  mem_fill_ctrl_if.master bus
);
  localparam int unsigned OFS_W = $clog2(WORDS);
  localparam int unsigned CNT_W = OFS_W + 1;
  localparam int unsigned BLK_W = ADDR_WIDTH - OFS_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iss_cnt;
  logic [CNT_W-1:0] r_rcv_cnt;
  logic [BLK_W-1:0] r_fill_blk;
  logic             w_issue;
  logic             w_rx;
  logic             w_wt;
  logic             w_done;
  logic             w_start;

  assign w_start = (r_state == S_IDLE) && bus.miss_req;

  // State, counters and latched block address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_iss_cnt  <= '0;
      r_rcv_cnt  <= '0;
      r_fill_blk <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_fill_blk <= bus.miss_addr[ADDR_WIDTH-1:OFS_W+1];
        r_iss_cnt  <= '0;
        r_rcv_cnt  <= '0;
      end else begin
        if (w_issue) r_iss_cnt <= r_iss_cnt + CNT_W'(1);
        if (w_rx)    r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
      end
    end
  end

  // Next state; completion is decided by counting returned valids only
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_rx    = 1'b0;
    w_wt    = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.miss_req)    w_next = S_ISSUE;
        else if (bus.wt_req) w_wt   = 1'b1;
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        w_rx    = bus.mem_rvalid;
        if (r_iss_cnt == CNT_W'(WORDS - 1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_rx = bus.mem_rvalid && (r_rcv_cnt != CNT_W'(WORDS));
        if ((r_rcv_cnt == CNT_W'(WORDS)) ||
            (w_rx && (r_rcv_cnt == CNT_W'(WORDS - 1))))
          w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory side: reads during ISSUE, write-through stores in IDLE, zero otherwise
  assign bus.mem_en    = w_issue | w_wt;
  assign bus.mem_wr    = w_wt;
  assign bus.mem_addr  = w_issue ? {r_fill_blk, r_iss_cnt[OFS_W-1:0], 1'b0} :
                         w_wt    ? {bus.wt_addr[ADDR_WIDTH-1:1], 1'b0}      :
                                   '0;
  assign bus.mem_wdata = w_wt ? bus.wt_data : 16'h0000;
  assign bus.wt_ack    = w_wt;

  // Cache side
  assign bus.fill_busy = (r_state != S_IDLE);
  assign bus.fill_we   = w_rx;
  assign bus.fill_word = w_rx ? r_rcv_cnt[OFS_W-1:0] : '0;
  assign bus.fill_data = w_rx ? bus.mem_rdata : 16'h0000;
  assign bus.fill_blk  = r_fill_blk;
  assign bus.tag_we    = w_done;
  assign bus.fill_done = w_done;
endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Directed bench for mem_fill_ctrl with a 4-cycle pipelined word memory model.
module tb_mem_fill_ctrl;
  localparam int unsigned AW    = 16;
  localparam int unsigned WORDS = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_fill_ctrl_if #(.ADDR_WIDTH(AW), .WORDS(WORDS)) bus ();

  mem_fill_ctrl #(.ADDR_WIDTH(AW), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: unwritten word w reads 0xA000+w; read data valid 4 cycles after issue
  logic [15:0] mem [logic [14:0]];
  logic [3:0]  pv;
  logic [14:0] pa0, pa1, pa2;
  logic [15:0] pd;
  logic        mem_clr;
  logic        inj_v;
  logic [15:0] inj_d;

  function automatic logic [15:0] mem_rd(input logic [14:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'(16'hA000 + 16'(a));
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[15:1]] = bus.mem_wdata;
    pv  <= mem_clr ? 4'b0000 : {pv[2:0], bus.mem_en & ~bus.mem_wr};
    pa0 <= bus.mem_addr[15:1];
    pa1 <= pa0;
    pa2 <= pa1;
    pd  <= mem_rd(pa2);
  end

  assign bus.mem_rvalid = pv[3] | inj_v;
  assign bus.mem_rdata  = pv[3] ? pd : inj_d;

  wire [57:0] w_obs = {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata,
                       bus.fill_we, bus.fill_word, bus.fill_data,
                       bus.tag_we, bus.fill_done, bus.wt_ack, bus.fill_busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1;
    tick(); tick();
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    n_tests++;
    if (w_obs !== 58'h0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", w_obs, 58'h0);
    end
    n_tests++;
    if (bus.fill_blk !== 12'h000) begin
      n_fail++; $display("FAIL reset_fill_blk got=%h want=%h", bus.fill_blk, 12'h000);
    end
    tick();
    inj_v = 1'b1; inj_d = 16'h1234;
    #1;
    n_tests++;
    if ({bus.fill_we, bus.fill_word, bus.fill_data, bus.fill_busy} !== 21'h0) begin
      n_fail++; $display("FAIL idle_rvalid_ignored we=%b data=%h want we=0 data=0000",
                         bus.fill_we, bus.fill_data);
    end
    tick();
    inj_v = 1'b0; inj_d = 16'h0000;
  endtask

  // Runs one fill from IDLE and checks every output for cycles 0..14
  task automatic test_fill(input logic [15:0] addr, input logic [15:0] d_first,
                           input logic [15:0] d_base);
    logic [57:0] exp;
    logic [15:0] base;
    logic [15:0] ea;
    logic [15:0] ed;
    logic        en, we;
    int          ofs;
    base = addr & 16'hFFF0;
    bus.miss_req = 1'b1; bus.miss_addr = addr;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.fill_busy, bus.wt_ack} !== 3'b000) begin
      n_fail++; $display("FAIL fill_c0 addr=%h en/busy/ack=%b want 000",
                         addr, {bus.mem_en, bus.fill_busy, bus.wt_ack});
    end
    tick();
    bus.miss_req = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      #1;
      en  = (c <= 8);
      we  = (c >= 5) && (c <= 12);
      ofs = c - 5;
      ea  = en ? 16'(base + 16'(2 * (c - 1))) : 16'h0000;
      ed  = !we ? 16'h0000 : (ofs == 0) ? d_first : 16'(d_base + 16'(ofs));
      exp = {en, 1'b0, ea, 16'h0000, we, we ? 3'(ofs) : 3'd0, ed,
             1'(c == 13), 1'(c == 13), 1'b0, 1'(c <= 13)};
      n_tests++;
      if (w_obs !== exp) begin
        n_fail++; $display("FAIL fill_%h_cycle%0d got=%h want=%h", addr, c, w_obs, exp);
      end
      if (c == 13) begin
        n_tests++;
        if (bus.fill_blk !== base[15:4]) begin
          n_fail++; $display("FAIL fill_blk got=%h want=%h", bus.fill_blk, base[15:4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_through();
    bus.wt_req = 1'b1; bus.wt_addr = 16'h0041; bus.wt_data = 16'hBEEF;
    #1;
    n_tests++;
    if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.wt_ack, bus.fill_busy}
        !== {1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL wt_idle en=%b wr=%b addr=%h wdata=%h ack=%b want 1 1 0040 beef 1",
                         bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.wt_ack);
    end
    tick();
    bus.wt_req = 1'b0;
    test_fill(16'h0040, 16'hBEEF, 16'hA020);
  endtask

  task automatic test_collision();
    bus.miss_req = 1'b1; bus.miss_addr = 16'h2000;
    bus.wt_req = 1'b1; bus.wt_addr = 16'h3002; bus.wt_data = 16'h5555;
    #1;
    n_tests++;
    if ({bus.wt_ack, bus.mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL collide_c0 ack/en=%b want 00", {bus.wt_ack, bus.mem_en});
    end
    tick();
    bus.miss_req = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      #1;
      n_tests++;
      if ({bus.wt_ack, bus.mem_en & bus.mem_wr, bus.fill_done} !== {2'b00, 1'(c == 13)}) begin
        n_fail++; $display("FAIL collide_cycle%0d ack/wr/done=%b want %b", c,
                           {bus.wt_ack, bus.mem_en & bus.mem_wr, bus.fill_done},
                           {2'b00, 1'(c == 13)});
      end
      tick();
    end
    #1;
    n_tests++;
    if ({bus.wt_ack, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.fill_busy}
        !== {1'b1, 1'b1, 1'b1, 16'h3002, 1'b0}) begin
      n_fail++; $display("FAIL collide_ack ack=%b en=%b wr=%b addr=%h want 1 1 1 3002",
                         bus.wt_ack, bus.mem_en, bus.mem_wr, bus.mem_addr);
    end
    tick();
    bus.wt_req = 1'b0;
  endtask

  task automatic test_reset_midfill();
    bus.miss_req = 1'b1; bus.miss_addr = 16'h1236;
    tick();
    bus.miss_req = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (w_obs !== 58'h0) begin
      n_fail++; $display("FAIL midfill_reset got=%h want=%h", w_obs, 58'h0);
    end
    for (int c = 8; c <= 12; c++) begin
      tick();
      #1;
      n_tests++;
      if ({bus.fill_we, bus.tag_we, bus.fill_done, bus.fill_busy} !== 4'b0000) begin
        n_fail++; $display("FAIL midfill_quiet_cycle%0d we/tag/done/busy=%b want 0000", c,
                           {bus.fill_we, bus.tag_we, bus.fill_done, bus.fill_busy});
      end
    end
    tick();
    test_fill(16'hFFF0, 16'h1FF8, 16'h1FF8);
  endtask

  task automatic test_back_to_back();
    int we1, we2, dn1, dn2;
    we1 = 0; we2 = 0; dn1 = 0; dn2 = 0;
    bus.miss_req = 1'b1; bus.miss_addr = 16'h4008;
    tick();
    for (int c = 1; c <= 28; c++) begin
      if (c == 15) bus.miss_req = 1'b0;
      #1;
      if (c <= 14) begin
        we1 += int'(bus.fill_we); dn1 += int'(bus.fill_done);
      end else begin
        we2 += int'(bus.fill_we); dn2 += int'(bus.fill_done);
      end
      if (c == 14) begin
        n_tests++;
        if ({bus.mem_en, bus.fill_busy} !== 2'b00) begin
          n_fail++; $display("FAIL b2b_idle en/busy=%b want 00", {bus.mem_en, bus.fill_busy});
        end
      end
      if (c == 15) begin
        n_tests++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.fill_busy}
            !== {1'b1, 1'b0, 16'h4000, 1'b1}) begin
          n_fail++; $display("FAIL b2b_second_issue en=%b wr=%b addr=%h busy=%b want 1 0 4000 1",
                             bus.mem_en, bus.mem_wr, bus.mem_addr, bus.fill_busy);
        end
      end
      tick();
    end
    n_tests++;
    if ({we1, dn1, we2, dn2} !== {32'd8, 32'd1, 32'd8, 32'd1}) begin
      n_fail++; $display("FAIL b2b_counts we1=%0d done1=%0d we2=%0d done2=%0d want 8 1 8 1",
                         we1, dn1, we2, dn2);
    end
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; inj_v = 1'b0; inj_d = 16'h0000;
    bus.miss_req = 1'b0; bus.miss_addr = 16'h0000;
    bus.wt_req = 1'b0; bus.wt_addr = 16'h0000; bus.wt_data = 16'h0000;
    test_reset();
    test_fill(16'h1236, 16'hA918, 16'hA918);
    test_write_through();
    test_collision();
    test_reset_midfill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_fill_ctrl.md
Name: mem_fill_ctrl

Overview:
- Initiator-side controller for the team's 16-bit, 4-cycle-read / 1-cycle-write word memory.
- On a cache miss, streams an 8-word (16-byte) block read: it issues one pipelined read per cycle and collects the returns by counting data_valid.
- Each returned word is delivered to the cache data array, followed by a tag-write strobe. In idle it also forwards single-cycle write-through stores.
- Sits between the I/D-cache miss logic and the memory.

Parameters:
- ADDR_WIDTH, 16, byte address width. Memory word address is addr[ADDR_WIDTH-1:1].
- WORDS, 8, words per cache block. Must be a power of 2. OFS_W = log2(WORDS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_req  in  1  block fill request; sampled only in IDLE
- miss_addr  in  ADDR_WIDTH  any byte address inside the missing block
- wt_req  in  1  write-through store request
- wt_addr  in  ADDR_WIDTH  store byte address; bit0 ignored and driven 0
- wt_data  in  16  store data
- wt_ack  out  1  store accepted and performed this cycle
- fill_busy  out  1  high in every non-IDLE state
- fill_we  out  1  write one word into the cache data array
- fill_word  out  OFS_W  word offset of fill_data
- fill_data  out  16  returned memory word
- fill_blk  out  ADDR_WIDTH-OFS_W-1  latched block address, i.e. miss_addr[ADDR_WIDTH-1:OFS_W+1]
- tag_we  out  1  one-cycle tag/valid write strobe
- fill_done  out  1  one-cycle completion pulse, coincident with tag_we
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write select
- mem_addr  out  ADDR_WIDTH  memory byte address; bit0 always 0
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory data_out
- mem_rvalid  in  1  memory data_valid

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE. Counters are iss_cnt and rcv_cnt, each OFS_W+1 bits wide.
- Reset (rst=1 at clk edge):
  - state goes to IDLE; iss_cnt = rcv_cnt = 0; fill_blk = 0.
  - All outputs read 0 in the cycle after reset: mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_word, fill_data, tag_we, fill_done, wt_ack, fill_busy.
  - Reset mid-fill abandons the fill: no tag_we and no fill_done.
- IDLE:
  - miss_req=1: latch fill_blk, clear both counters, go to ISSUE. No memory access this cycle.
  - miss_req=0 and wt_req=1: combinationally drive mem_en=1, mem_wr=1, mem_addr={wt_addr[15:1],0}, mem_wdata=wt_data, and wt_ack=1 in the same cycle. State stays IDLE.
  - miss_req has priority over wt_req. A deferred wt_req sees wt_ack=0 and must hold until acked.
  - mem_rvalid in IDLE is ignored: no fill_we.
- ISSUE:
  - Each cycle drive mem_en=1, mem_wr=0, mem_addr={fill_blk, iss_cnt[OFS_W-1:0], 1'b0}, then iss_cnt++.
  - After the issue with iss_cnt=WORDS-1, go to DRAIN.
  - Exactly WORDS reads are issued, in ascending offset order, one per cycle, back to back.
- Receive path (ISSUE or DRAIN):
  - When mem_rvalid=1: fill_we=1, fill_word=rcv_cnt[OFS_W-1:0], fill_data=mem_rdata (combinational), then rcv_cnt++.
  - The receive path runs concurrently with issuing. Completion is detected by counting valids, never by cycle count.
- DRAIN: mem_en=0. When rcv_cnt reaches WORDS (the last valid has been consumed), go to DONE.
- DONE: tag_we=1 and fill_done=1 for exactly one cycle; go to IDLE. wt_req is not serviced in DONE.
- Nominal timing, with miss_req sampled at edge E0:
  - reads issued in cycles 1..8;
  - fill_we in cycles 5..12 (offsets 0..7);
  - tag_we/fill_done in cycle 13;
  - back in IDLE in cycle 14.
- wt_req during a fill (busy): wt_ack=0, and no memory write occurs.
- Address wrap: offsets wrap within the block only; fill_blk never increments. A block at 0xFFF0 reads 0xFFF0..0xFFFE.
- mem_addr is X-free in all states: it is driven 0 when mem_en=0.

Test Plan:
- Reset, then idle: every output 0; a mem_rvalid=1 pulse in IDLE -> fill_we stays 0.
- miss_req, miss_addr=0x1236, memory preloaded with mem[word i]=0xA000+i:
  - mem_addr = 0x1230, 0x1232 .. 0x123E in cycles 1..8;
  - fill_we at cycles 5..12 with fill_word 0..7 and fill_data 0xA918..0xA91F;
  - tag_we/fill_done at cycle 13 with fill_blk=0x123.
- wt_req addr=0x0041, data=0xBEEF in IDLE:
  - same-cycle mem_en=1, mem_wr=1, mem_addr=0x0040, wt_ack=1;
  - a subsequent fill of 0x0040 returns 0xBEEF at fill_word 0.
- miss_req and wt_req asserted together: fill starts and wt_ack=0 throughout the fill; the store is acked in the cycle after fill_done (first IDLE cycle).
- rst asserted in cycle 6 of a fill: next cycle all outputs 0 and no tag_we; a new fill at 0xFFF0 completes with addresses 0xFFF0..0xFFFE and no wrap into 0x0000.
- Two back-to-back fills (miss_req held): the second starts issuing in the cycle after IDLE is entered, and each produces exactly 8 fill_we pulses and 1 fill_done.
